// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch engine with a small FWFT queue toward decode
module ifetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:2] id_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [31:0]     instr_mem [DEPTH];
    logic [31:2]     pc_mem    [DEPTH];
    logic            ack_busy, pop, push, space, issue;

    // Space is judged on the post-edge occupancy, so a push can never meet a full queue.
    always_comb begin
        ack_busy = (state == BUSY) && imem_ack;
        pop      = id_valid && id_ready;
        push     = ack_busy && !flush;
        cnt_nxt  = cnt + CW'(push) - CW'(pop);
        space    = cnt_nxt < CW'(DEPTH);
        issue    = !flush && space && ((state == IDLE) || ack_busy);
        pc_en    = !rst && (issue || flush);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = BUSY;
            BUSY: begin
                if (imem_ack)   state_nxt = issue ? BUSY : IDLE;
                else if (flush) state_nxt = DROP;
            end
            DROP: if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt != IDLE);
            if (issue) imem_addr <= pc;
        end
    end

    // Flush wins over a concurrent pop or push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wptr] <= imem_rdata;
            pc_mem[wptr]    <= imem_addr;
        end
    end

    assign id_valid = (cnt != '0);
    assign id_instr = instr_mem[rptr];
    assign id_pc    = pc_mem[rptr];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue against a queue-based fetch model
module tb_ifetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:2] pc;
    logic        pc_en;
    logic        flush = 1'b0;
    logic [31:2] tgt = '0;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:2] id_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wst      = 0;
    int          wcnt     = 0;
    logic        rmode    = 1'b0;
    logic        rbit     = 1'b0;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F11;
    endfunction

    // Environment: PC register and a wait-state memory in the same reset domain.
    always @(posedge clk or posedge rst) begin
        if (rst)        pc <= 30'h0C00;
        else if (pc_en) pc <= flush ? tgt : pc + 30'd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                       wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    assign imem_ack   = imem_req && (rmode ? rbit : (wcnt >= wst));
    assign imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an in-flight read (address, kept or dropped) and a queue of entries.
    logic [61:0] mq[$];
    logic        m_infl = 1'b0, m_kept = 1'b0;
    logic [29:0] m_addr = '0;

    always @(negedge clk) begin
        logic e_valid, m_ack, m_pop, m_push, m_iss;
        int   cn;
        if (rst) begin
            mq.delete();
            m_infl = 1'b0;
            m_kept = 1'b0;
            chk("rst_req",   64'(imem_req), 64'(0));
            chk("rst_valid", 64'(id_valid), 64'(0));
            chk("rst_pc_en", 64'(pc_en),    64'(0));
        end else begin
            e_valid = (mq.size() != 0);
            chk("req", 64'(imem_req), 64'(m_infl));
            if (m_infl) chk("addr", 64'(imem_addr), 64'(m_addr));
            chk("valid", 64'(id_valid), 64'(e_valid));
            if (e_valid) begin
                chk("id_pc",    64'(id_pc),    64'(mq[0][29:0]));
                chk("id_instr", 64'(id_instr), 64'(mq[0][61:30]));
            end
            m_ack  = m_infl && imem_ack;
            m_pop  = e_valid && id_ready;
            m_push = m_ack && m_kept && !flush;
            cn     = mq.size() + int'(m_push) - int'(m_pop);
            m_iss  = !flush && (cn < DEPTH) && (!m_infl || (m_ack && m_kept));
            chk("pc_en", 64'(pc_en), 64'(m_iss || flush));
            if (flush) mq.delete();
            else begin
                if (m_pop)  mq.delete(0);
                if (m_push) mq.push_back({memf(m_addr), m_addr});
            end
            if (m_iss) begin
                m_infl = 1'b1;
                m_kept = 1'b1;
                m_addr = pc;
            end else if (m_ack) m_infl = 1'b0;
            else if (flush)     m_kept = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller in the first cycle after reset release (cycle C0).
    task automatic start(input int w, input logic rdy);
        cyc();
        rst = 1'b1; flush = 1'b0; rmode = 1'b0; wst = w; id_ready = rdy;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int pe, vc, stale;

        // Zero-wait streaming from reset.
        start(0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("t1_req",  64'(imem_req),  64'(1));
            chk("t1_addr", 64'(imem_addr), 64'(30'h0C00 + 30'(i - 1)));
            if (i >= 2) begin
                chk("t1_valid", 64'(id_valid), 64'(1));
                chk("t1_id_pc", 64'(id_pc),    64'(30'h0C00 + 30'(i - 2)));
                chk("t1_instr", 64'(id_instr), 64'(memf(30'h0C00 + 30'(i - 2))));
            end
        end

        // Three wait states.
        start(3, 1'b1);
        pe = 0; vc = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(); #1;
            pe += int'(pc_en);
            vc += int'(id_valid);
        end
        chk("t2_pc_en_cnt", 64'(pe),        64'(4));
        chk("t2_valid_cnt", 64'(vc),        64'(3));
        chk("t2_addr",      64'(imem_addr), 64'(30'h0C03));

        // Backpressure from reset fills the queue then stalls the PC.
        start(0, 1'b0);
        #1;
        pe = int'(pc_en);
        for (int i = 1; i <= 5; i++) begin
            cyc(); #1;
            pe += int'(pc_en);
        end
        chk("t3_fetches", 64'(pe),       64'(2));
        chk("t3_req",     64'(imem_req), 64'(0));
        chk("t3_pc",      64'(pc),       64'(30'h0C02));
        chk("t3_head0",   64'(id_pc),    64'(30'h0C00));
        id_ready = 1'b1;
        #1;
        chk("t3_resume_pc_en", 64'(pc_en), 64'(1));
        cyc(); #1;
        chk("t3_head1",  64'(id_pc),     64'(30'h0C01));
        chk("t3_addr_r", 64'(imem_addr), 64'(30'h0C02));

        // Flush in BUSY with an ack pending three cycles out.
        start(3, 1'b1);
        cyc();
        cyc();
        flush = 1'b1; tgt = 30'h0D00;
        #1;
        chk("t4_flush_pc_en", 64'(pc_en), 64'(1));
        cyc();
        flush = 1'b0;
        #1;
        chk("t4_drop_req",  64'(imem_req),  64'(1));
        chk("t4_drop_addr", 64'(imem_addr), 64'(30'h0C00));
        stale = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            if (k == 3) chk("t4_redirect_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 30'h0D00}));
            stale += int'(id_valid && (id_pc == 30'h0C00));
        end
        chk("t4_stale", 64'(stale), 64'(0));

        // Flush with a full queue while decode is popping.
        start(0, 1'b0);
        for (int i = 1; i <= 4; i++) cyc();
        id_ready = 1'b1; flush = 1'b1; tgt = 30'h1234;
        #1;
        chk("t5_full_valid", 64'(id_valid), 64'(1));
        cyc();
        flush = 1'b0;
        #1;
        chk("t5_after_valid", 64'(id_valid), 64'(0));
        cyc(); #1;
        chk("t5_gap_valid", 64'(id_valid), 64'(0));
        cyc(); #1;
        chk("t5_new_head", 64'({id_valid, id_pc}), 64'({1'b1, 30'h1234}));

        // Reset in the middle of a read.
        start(3, 1'b1);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_req",   64'(imem_req), 64'(0));
        chk("t6_valid", 64'(id_valid), 64'(0));
        chk("t6_pc_en", 64'(pc_en),    64'(0));
        cyc();
        cyc();
        rst = 1'b0;
        cyc(); #1;
        chk("t6_restart", 64'({imem_req, imem_addr}), 64'({1'b1, 30'h0C00}));

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (i % 250 == 0) begin
                rmode = 1'($urandom % 2);
                wst   = int'($urandom % 4);
            end
            id_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 20) == 0;
            tgt      = 30'($urandom);
            rbit     = 1'($urandom % 2);
            rst      = ($urandom % 500) == 0;
        end
        cyc();
        rst = 1'b0; flush = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
